axi_dma_item_fifo: RTL and testbench
====================================

// Module: axi_dma_item_fifo
// PURPOSE
//   Buffers fixed-width items from a non-stallable producer (CPU trace/metric source) and presents
//   them as an AXI-Stream master to the DMA stream controller, which frames them with tlast.
//   The producer has no ready; when the buffer is full, items are dropped and counted.
//   Output is first-word-fall-through: the head item is on m_axis_tdata whenever tvalid is high.
// PARAMETERS
//   TDATA_WIDTH  128  item / stream data width in bits
//   DEPTH_LOG2   4    log2 of FIFO depth (depth = 2**DEPTH_LOG2 items, >= 2)
// PORTS
//   clk             in   1                  clock; all logic on rising edge
//   rst             in   1                  synchronous, active-high reset
//   s_item_valid    in   1                  producer presents an item this cycle
//   s_item_data     in   TDATA_WIDTH        producer item
//   flush           in   1                  synchronous discard of all buffered items
//   overflow_clear  in   1                  clears overflow_count
//   m_axis_tready   in   1                  downstream accepts head item
//   m_axis_tvalid   out  1                  head item valid (FIFO not empty)
//   m_axis_tdata    out  TDATA_WIDTH        head item
//   fill_level      out  DEPTH_LOG2+1       items currently stored, 0..2**DEPTH_LOG2
//   full            out  1                  fill_level == 2**DEPTH_LOG2
//   overflow_count  out  32                 items dropped since reset/clear, saturating
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): wr_ptr, rd_ptr, fill_level, overflow_count <= 0; next cycle
//     m_axis_tvalid=0, full=0, fill_level=0. Memory contents are not reset; tdata is don't-care while
//     tvalid=0. Reset mid-operation discards all buffered items; no partial item is ever emitted.
//   - push = s_item_valid & (!full | pop); pop = m_axis_tvalid & m_axis_tready.
//   - Push writes mem[wr_ptr], wr_ptr += 1 (wraps mod depth). Pop: rd_ptr += 1 (wraps).
//   - fill_level: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
//   - m_axis_tvalid = (fill_level != 0); m_axis_tdata = mem[rd_ptr]; both derive from registers only
//     (no combinational path from s_item_* or m_axis_tready to outputs).
//   - Latency: an item pushed at edge N into an empty FIFO appears with tvalid=1 after edge N (1 cycle).
//   - Full and pop in the same cycle: the incoming item IS accepted, fill_level stays at depth.
//   - Full, no pop, s_item_valid=1: item dropped, overflow_count += 1, saturating at 32'hFFFF_FFFF.
//   - Empty and s_item_valid=1: item written; no bypass, tvalid rises the following cycle.
//   - AXIS rule: once tvalid=1 the head item and tvalid remain stable until pop, except on rst/flush.
//   - flush=1: ptrs and fill_level <= 0 next cycle; a simultaneous push is discarded and NOT counted
//     as overflow; a simultaneous pop has no further effect. overflow_count is unaffected by flush.
//   - overflow_clear=1: overflow_count <= 0; if a drop occurs in the same cycle, overflow_count <= 1.
//   - Priority: rst > flush > push/pop. overflow_clear is independent of flush.
// TESTING
//   1. rst held 2 cycles mid-stream with 5 items buffered -> tvalid=0, fill_level=0, overflow_count=0
//      next cycle; no stale item emitted after release.
//   2. Push 0x1..0x3 on consecutive cycles, tready=0; then tready=1 -> tdata 0x1,0x2,0x3 in order,
//      tvalid drops after the 3rd pop; fill_level traces 1,2,3,2,1,0.
//   3. DEPTH_LOG2=4: push 18 items with tready=0 -> full=1 after 16th, overflow_count=2, items 0..15
//      drained intact; then a push while full with tready=1 -> accepted, fill_level stays 16.
//   4. Continuous push+pop each cycle for 100 cycles across pointer wrap -> fill_level constant,
//      output sequence equals input sequence, overflow_count=0.
//   5. flush with simultaneous push at fill_level=7 -> fill_level=0, tvalid=0, overflow_count unchanged.
//   6. overflow_count forced near saturation (2**32-1 drops via force/preload) -> stays 32'hFFFF_FFFF;
//      overflow_clear with simultaneous drop -> overflow_count=1.

Source files
------------

// File: rtl/axi_dma_item_fifo.sv
// First-word-fall-through item FIFO feeding an AXI-Stream master from a producer
// that cannot be stalled; items arriving while full are dropped and counted.
module axi_dma_item_fifo #(
   parameter int TDATA_WIDTH = 128,
   parameter int DEPTH_LOG2  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_item_valid,
   input  logic [TDATA_WIDTH-1:0] s_item_data,
   input  logic                   flush,
   input  logic                   overflow_clear,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tvalid,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic [DEPTH_LOG2:0]    fill_level,
   output logic                   full,
   output logic [31:0]            overflow_count
);

   localparam int unsigned         DEPTH     = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_LVL = DEPTH[DEPTH_LOG2:0];
   localparam logic [31:0]         CNT_MAX   = 32'hFFFF_FFFF;

   logic [TDATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  wr_ptr;
   logic [DEPTH_LOG2-1:0]  rd_ptr;
   logic [DEPTH_LOG2:0]    level;
   logic [31:0]            ovf_cnt;

   logic not_empty;
   logic is_full;
   logic push;
   logic pop;
   logic drop;

   // Status is derived from registered state only, so no input reaches an output combinationally.
   assign not_empty = (level != '0);
   assign is_full   = (level == DEPTH_LVL);

   // A pop frees the slot in the same cycle, so a full FIFO still accepts when draining.
   assign pop  = not_empty & m_axis_tready;
   assign push = s_item_valid & (~is_full | pop);
   // Items discarded by a flush are not overflow drops.
   assign drop = s_item_valid & ~push & ~flush;

   // NOTE: storage has no reset; contents are only observable while level says they are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_item_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Clear and drop in the same cycle leaves a count of one, so that drop is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt <= '0;
      end else if (overflow_clear) begin
         ovf_cnt <= {31'b0, drop};
      end else if (drop && (ovf_cnt != CNT_MAX)) begin
         ovf_cnt <= ovf_cnt + 32'd1;
      end
   end

   assign m_axis_tvalid  = not_empty;
   assign m_axis_tdata   = mem[rd_ptr];
   assign fill_level     = level;
   assign full           = is_full;
   assign overflow_count = ovf_cnt;

endmodule

// File: tb/tb_axi_dma_item_fifo.sv
// Randomized and directed bench for axi_dma_item_fifo against a queue-based reference model.
module tb_axi_dma_item_fifo;

   localparam int TW    = 128;
   localparam int DL2   = 4;
   localparam int DEPTH = 2 ** DL2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            s_item_valid = 1'b0;
   logic [TW-1:0]   s_item_data = '0;
   logic            flush = 1'b0;
   logic            overflow_clear = 1'b0;
   logic            m_axis_tready = 1'b0;
   logic            m_axis_tvalid;
   logic [TW-1:0]   m_axis_tdata;
   logic [DL2:0]    fill_level;
   logic            full;
   logic [31:0]     overflow_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: ordered list of stored items plus the drop counter.
   logic [TW-1:0] mq[$];
   logic [31:0]   movf = '0;

   axi_dma_item_fifo #(.TDATA_WIDTH(TW), .DEPTH_LOG2(DL2)) dut (
      .clk(clk), .rst(rst),
      .s_item_valid(s_item_valid), .s_item_data(s_item_data),
      .flush(flush), .overflow_clear(overflow_clear),
      .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tdata(m_axis_tdata), .fill_level(fill_level),
      .full(full), .overflow_count(overflow_count)
   );

   always #5 clk = ~clk;

   function automatic logic [TW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drives one clock of stimulus and advances the model; outputs are stable at return.
   task automatic cycle(input bit v, input logic [TW-1:0] d, input bit rdy,
                        input bit fl, input bit clr, input bit r);
      bit mpop, mpush, mdrop;
      @(negedge clk);
      s_item_valid = v; s_item_data = d; m_axis_tready = rdy;
      flush = fl; overflow_clear = clr; rst = r;
      mpop  = (mq.size() > 0) && rdy;
      mpush = v && ((mq.size() < DEPTH) || mpop);
      mdrop = v && !mpush && !fl;
      @(posedge clk);
      #1;
      if (r) begin
         mq.delete();
         movf = '0;
      end else begin
         if (fl) mq.delete();
         else begin
            if (mpop)  void'(mq.pop_front());
            if (mpush) mq.push_back(d);
         end
         if (clr) movf = mdrop ? 32'd1 : 32'd0;
         else if (mdrop && movf != 32'hFFFF_FFFF) movf = movf + 32'd1;
      end
   endtask

   task automatic idle();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (m_axis_tvalid !== 1'b0 || fill_level !== '0 || full !== 1'b0 || overflow_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: tvalid=%b fill=%0d full=%b ovf=%0d, want 0/0/0/0",
                  m_axis_tvalid, fill_level, full, overflow_count);
      end
      // Fill to overflow so a reset of the drop counter is observable, then leave 5 items.
      for (int i = 0; i < DEPTH + 3; i++) cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (fill_level !== 5'd5 || overflow_count !== 32'd3) begin
         n_fail++;
         $display("FAIL reset_prefill: fill=%0d ovf=%0d, want 5/3", fill_level, overflow_count);
      end
      cycle(1'b1, rnd128(), 1'b1, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (m_axis_tvalid !== 1'b0 || fill_level !== '0 || overflow_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_midstream: tvalid=%b fill=%0d ovf=%0d, want 0/0/0",
                  m_axis_tvalid, fill_level, overflow_count);
      end
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
         n_checks++;
         if (m_axis_tvalid !== 1'b0 || fill_level !== '0) begin
            n_fail++;
            $display("FAIL reset_no_stale: tvalid=%b fill=%0d, want 0/0", m_axis_tvalid, fill_level);
         end
      end
   endtask

   task automatic test_order();
      logic [DL2:0] exp_fill [6] = '{5'd1, 5'd2, 5'd3, 5'd2, 5'd1, 5'd0};
      logic [TW-1:0] head;
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, TW'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
         n_checks++;
         if (fill_level !== exp_fill[i] || m_axis_tvalid !== 1'b1 || m_axis_tdata !== TW'(1)) begin
            n_fail++;
            $display("FAIL order_push%0d: fill=%0d tvalid=%b tdata=%h, want %0d/1/1",
                     i, fill_level, m_axis_tvalid, m_axis_tdata, exp_fill[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         head = m_axis_tdata;
         n_checks++;
         if (head !== TW'(i + 1)) begin
            n_fail++;
            $display("FAIL order_head%0d: tdata=%h, want %h", i, head, TW'(i + 1));
         end
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
         n_checks++;
         if (fill_level !== exp_fill[i + 3] || m_axis_tvalid !== (i < 2)) begin
            n_fail++;
            $display("FAIL order_pop%0d: fill=%0d tvalid=%b, want %0d/%0b",
                     i, fill_level, m_axis_tvalid, exp_fill[i + 3], (i < 2));
         end
      end
   endtask

   task automatic test_overflow();
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH + 2; i++) begin
         cycle(1'b1, TW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         if (i == DEPTH - 2 || i == DEPTH - 1) begin
            n_checks++;
            if (full !== (i == DEPTH - 1)) begin
               n_fail++;
               $display("FAIL overflow_full_at%0d: full=%b, want %0b", i + 1, full, (i == DEPTH - 1));
            end
         end
      end
      n_checks++;
      if (overflow_count !== 32'd2 || fill_level !== 5'd16 || m_axis_tdata !== TW'(0)) begin
         n_fail++;
         $display("FAIL overflow_count: ovf=%0d fill=%0d head=%h, want 2/16/0",
                  overflow_count, fill_level, m_axis_tdata);
      end
      cycle(1'b1, TW'(100), 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (fill_level !== 5'd16 || full !== 1'b1 || overflow_count !== 32'd2) begin
         n_fail++;
         $display("FAIL overflow_push_pop_full: fill=%0d full=%b ovf=%0d, want 16/1/2",
                  fill_level, full, overflow_count);
      end
      for (int i = 1; i <= DEPTH; i++) begin
         n_checks++;
         if (m_axis_tdata !== ((i == DEPTH) ? TW'(100) : TW'(i)) || m_axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_drain%0d: tdata=%h tvalid=%b", i, m_axis_tdata, m_axis_tvalid);
         end
         cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      n_checks++;
      if (m_axis_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_empty: tvalid=%b, want 0", m_axis_tvalid);
      end
   endtask

   task automatic test_back_to_back();
      logic [TW-1:0] sent[$];
      int            mism = 0;
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         sent.push_back(rnd128());
         cycle(1'b1, sent[$], 1'b0, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 100; i++) begin
         n_checks++;
         if (m_axis_tdata !== sent[i]) begin
            n_fail++; mism++;
            if (mism < 5) $display("FAIL b2b_data%0d: tdata=%h, want %h", i, m_axis_tdata, sent[i]);
         end
         sent.push_back(rnd128());
         cycle(1'b1, sent[$], 1'b1, 1'b0, 1'b0, 1'b0);
         n_checks++;
         if (fill_level !== 5'd5 || overflow_count !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_level%0d: fill=%0d ovf=%0d, want 5/0", i, fill_level, overflow_count);
         end
      end
   endtask

   task automatic test_flush();
      logic [31:0] ovf_before;
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH - 7; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      ovf_before = overflow_count;
      n_checks++;
      if (fill_level !== 5'd7 || ovf_before !== 32'd1) begin
         n_fail++;
         $display("FAIL flush_setup: fill=%0d ovf=%0d, want 7/1", fill_level, ovf_before);
      end
      cycle(1'b1, rnd128(), 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (fill_level !== '0 || m_axis_tvalid !== 1'b0 || overflow_count !== 32'd1) begin
         n_fail++;
         $display("FAIL flush_with_push: fill=%0d tvalid=%b ovf=%0d, want 0/0/1",
                  fill_level, m_axis_tvalid, overflow_count);
      end
      // A flush while full with an incoming item must not count a drop.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, rnd128(), 1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (fill_level !== '0 || overflow_count !== 32'd1) begin
         n_fail++;
         $display("FAIL flush_full: fill=%0d ovf=%0d, want 0/1", fill_level, overflow_count);
      end
   endtask

   task automatic test_saturation();
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      force dut.ovf_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.ovf_cnt;
      movf = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b0, 1'b0);
         n_checks++;
         if (overflow_count !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_drop%0d: ovf=%h, want ffffffff", i, overflow_count);
         end
      end
      cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (overflow_count !== 32'd1) begin
         n_fail++;
         $display("FAIL sat_clear_with_drop: ovf=%0d, want 1", overflow_count);
      end
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (overflow_count !== 32'd0) begin
         n_fail++;
         $display("FAIL sat_clear: ovf=%0d, want 0", overflow_count);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(99) < 60, rnd128(), $urandom_range(99) < 50,
               $urandom_range(199) == 0, $urandom_range(99) < 2, $urandom_range(499) == 0);
         n_checks++;
         if (fill_level !== ($bits(fill_level))'(mq.size()) || m_axis_tvalid !== (mq.size() > 0) ||
             full !== (mq.size() == DEPTH) || overflow_count !== movf ||
             (mq.size() > 0 && m_axis_tdata !== mq[0])) begin
            n_fail++; errs++;
            if (errs < 5)
               $display("FAIL random%0d: fill=%0d/%0d tvalid=%b full=%b ovf=%0d/%0d tdata=%h",
                        i, fill_level, mq.size(), m_axis_tvalid, full, overflow_count, movf,
                        m_axis_tdata);
         end
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_overflow();
      test_back_to_back();
      test_flush();
      test_saturation();
      test_random();
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
